// File: rtl/hazard_ctl.sv
// Load-use / memory-stall / branch-flush hazard control with saturating perf counters.
// Zero latency: stage-register enables are combinational; the pipe freezes while mem_busy holds.
module hazard_ctl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   branch_pending;
  logic   load_use;
  logic   hold;
  logic   take_branch;
  logic   do_bubble;

  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // Leaving MEM_WAIT is zero-cycle: once busy drops the cycle is judged exactly like RUN.
  always_comb begin
    hold = 1'b0;
    case (state)
      RUN:      hold = mem_busy;
      MEM_WAIT: hold = mem_busy;
    endcase
  end

  assign take_branch = !hold && (branch_taken || branch_pending);
  assign do_bubble   = !hold && !take_branch && load_use;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (take_branch) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (do_bubble) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      branch_pending <= 1'b0;
      stall_cycles   <= '0;
      flush_events   <= '0;
    end else begin
      state <= hold ? MEM_WAIT : RUN;
      // A branch resolved under a freeze is remembered until the pipe can flush.
      if (hold) begin
        if (branch_taken) branch_pending <= 1'b1;
      end else begin
        branch_pending <= 1'b0;
      end
      if ((hold || do_bubble) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_ONE;
      if (take_branch && (flush_events != '1))
        flush_events <= flush_events + CNT_ONE;
    end
  end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Pipeline hazard controller. It drives the write-enable, bubble and flush inputs of the IF/ID, ID/EX and EX/MEM stage registers.
- It reads the memread bit and rt field already held in ID/EX, plus the rs/rt fields of the instruction in ID.
- It inserts load-use bubbles, freezes the pipe during multi-cycle memory accesses, and flushes on taken branches resolved in MEM.
- A branch that resolves during a memory stall is held pending until the stall ends.
- It also keeps saturating performance counters for stall cycles and flushes.

Parameters:
CNT_W, 16, width of the stall_cycles and flush_events counters

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
idex_memread  input  1  memread bit of the ID/EX m control field
idex_rt  input  5  rt field (bits 20:16) held in ID/EX
ifid_rs  input  5  rs field of the instruction in ID
ifid_rt  input  5  rt field of the instruction in ID
ifid_uses_rt  input  1  instruction in ID reads rt as a source
branch_taken  input  1  taken branch resolved in MEM this cycle
mem_busy  input  1  data memory access not complete; pipe must hold
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID load enable
idex_write  output  1  ID/EX load enable
exmem_write  output  1  EX/MEM load enable
idex_bubble  output  1  load zero control fields into ID/EX instead of ID outputs
ifid_flush  output  1  clear IF/ID to NOP
idex_flush  output  1  clear ID/EX control fields
exmem_flush  output  1  clear EX/MEM control fields
stall_cycles  output  CNT_W  saturating count of stalled cycles
flush_events  output  CNT_W  saturating count of branch flushes

Behaviour:
- State register: RUN, MEM_WAIT. Plus a branch_pending flag and the two counters. All are cleared by rst_n low, asynchronously.
- Control outputs are combinational from state, branch_pending and inputs. They take effect at the same clock edge as the stage registers.
- While rst_n is low:
  - All *_write = 0, idex_bubble = 0.
  - All *_flush = 1.
  - Counters = 0.
- load_use = idex_memread AND idex_rt != 0 AND (idex_rt == ifid_rs OR (ifid_uses_rt AND idex_rt == ifid_rt)).
- Default (no event): all writes 1, bubble 0, flushes 0.
- Priority, highest first: mem_busy, pending/new branch, load_use.
- RUN with mem_busy = 1:
  - All writes 0, bubble 0, flushes 0.
  - If branch_taken, set branch_pending.
  - Next state MEM_WAIT. stall_cycles += 1.
- RUN with mem_busy = 0 and (branch_taken or branch_pending):
  - ifid_flush = idex_flush = exmem_flush = 1; writes 1.
  - Clear branch_pending. flush_events += 1 (once, even if both are set).
  - load_use is ignored this cycle.
- RUN with mem_busy = 0, no branch, load_use = 1:
  - pc_write = 0, ifid_write = 0, idex_bubble = 1; idex_write and exmem_write = 1.
  - stall_cycles += 1. Exactly one bubble per hazard; the hazard clears because ID/EX then holds memread = 0.
- MEM_WAIT with mem_busy = 1: freeze as above, stall_cycles += 1. branch_taken sets branch_pending, and it stays set.
- MEM_WAIT with mem_busy = 0:
  - Go to RUN. Outputs this cycle are evaluated exactly as in RUN, so the pending flush or a load-use bubble is issued in this same cycle.
  - Zero-cycle exit: a busy pulse of N cycles costs exactly N stall cycles.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or with a branch pending: state returns to RUN, the pending branch is discarded, counters clear. The first cycle after release is a normal RUN cycle.
- idex_rt == 0 never causes a stall.

Test Plan:
1. Load-use stall: idex_memread = 1, idex_rt = 5, ifid_rs = 5, mem_busy = 0 for one cycle -> pc_write = 0, ifid_write = 0, idex_bubble = 1 that cycle; stall_cycles 0 -> 1. Next cycle idex_memread = 0 -> all writes 1, bubble 0.
2. No false stall: same as scenario 1 but ifid_uses_rt = 0, ifid_rt = 5, ifid_rs = 3; then a separate case with idex_rt = 0, ifid_rs = 0 -> no stall in either, stall_cycles stays 0.
3. Taken branch plus hazard: branch_taken = 1 while load_use = 1 -> three flushes = 1, idex_bubble = 0, pc_write = 1; flush_events = 1, stall_cycles unchanged.
4. Branch during memory stall: mem_busy = 1 for 4 cycles with branch_taken pulsed in cycle 2 ->
   - writes 0 and flushes 0 for all 4 cycles;
   - in the cycle mem_busy falls, flushes = 1;
   - stall_cycles = 4, flush_events = 1.
5. Reset mid-wait: mem_busy = 1 for 2 cycles with branch_pending set, then rst_n low 1 cycle, rst_n high with mem_busy = 0 ->
   - during reset all flushes 1 and writes 0;
   - after release: state RUN, no flush, counters 0.
6. Saturation: CNT_W = 4, hold mem_busy = 1 for 20 cycles -> stall_cycles reaches 15 and stays 15.
